// File: rtl/uart_pkg.sv
// Shared UART types and default sizing for the transceiver slice.
package uart_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CPB    = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_transceiver_if.sv
// Parallel-side handshake plus serial lines of the UART transceiver.
interface uart_transceiver_if import uart_pkg::*; #(parameter int W = DEF_DATA_W);
  logic         enable;
  logic [W-1:0] i_data;
  logic         o_busy;
  logic         serial_out;
  logic         serial_in;
  logic [W-1:0] received_data;
  logic         data_is_valid;
  logic         rx_error;

  modport slave (
    input  enable, i_data, serial_in,
    output o_busy, serial_out, received_data, data_is_valid, rx_error
  );

  modport master (
    output enable, i_data, serial_in,
    input  o_busy, serial_out, received_data, data_is_valid, rx_error
  );
endinterface

// File: rtl/uart_rx.sv
// Mid-bit sampling deserialiser with 2-FF input synchroniser and framing check.
module uart_rx import uart_pkg::*; #(
  parameter int W   = DEF_DATA_W,
  parameter int CPB = DEF_CPB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         error
);
  localparam int CW = $clog2(CPB);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic          sync1, line, prev;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [W-1:0]  sh, sh_n;
  logic [W-1:0]  data_n;
  logic          valid_n, error_n;
  logic          tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial;
      line  <= sync1;
      prev  <= line;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      data  <= '0;
      valid <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      data  <= data_n;
      valid <= valid_n;
      error <= error_n;
    end
  end

  // Start needs a high-to-low transition, so a line stuck low after a
  // framing error cannot retrigger a frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data;
    valid_n = 1'b0;
    error_n = 1'b0;
    if (state != RX_IDLE)
      cnt_n = tick ? CW'(CPB - 1) : cnt - 1'b1;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (prev && !line) begin
          state_n = RX_START;
          cnt_n   = CW'(CPB / 2 - 1);
        end
      end
      RX_START: begin
        if (tick) begin
          idx_n   = '0;
          state_n = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tick) begin
          sh_n = {line, sh[W-1:1]};
          if (idx == IW'(W - 1)) state_n = RX_STOP;
          else                   idx_n   = idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          state_n = RX_IDLE;
          if (line) begin
            data_n  = sh;
            valid_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1-style serialiser: start bit, W data bits LSB first, one stop bit.
module uart_tx import uart_pkg::*; #(
  parameter int W   = DEF_DATA_W,
  parameter int CPB = DEF_CPB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic         busy,
  output logic         line
);
  localparam int CW = $clog2(CPB);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  tx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [W-1:0]  sh, sh_n;
  logic          busy_n, line_n;
  logic          last;

  assign last = (cnt == CW'(CPB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      busy  <= 1'b0;
      line  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      busy  <= busy_n;
      line  <= line_n;
    end
  end

  // Output registers are loaded with the value of the bit being entered,
  // so serial_out changes exactly on bit boundaries.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    busy_n  = busy;
    line_n  = line;
    case (state)
      TX_IDLE: begin
        busy_n = 1'b0;
        line_n = 1'b1;
        if (enable) begin
          sh_n    = data;
          cnt_n   = '0;
          state_n = TX_START;
          busy_n  = 1'b1;
          line_n  = 1'b0;
        end
      end
      TX_START: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = TX_DATA;
          line_n  = sh[0];
        end
      end
      TX_DATA: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n = '0;
          if (idx == IW'(W - 1)) begin
            state_n = TX_STOP;
            line_n  = 1'b1;
          end else begin
            idx_n  = idx + 1'b1;
            sh_n   = sh >> 1;
            line_n = sh[1];
          end
        end
      end
      TX_STOP: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n   = '0;
          state_n = TX_IDLE;
          busy_n  = 1'b0;
          line_n  = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: independent TX and RX engines sharing one clock.
module uart_transceiver import uart_pkg::*; #(
  parameter int INPUT_DATA_WIDTH = DEF_DATA_W,
  parameter int CLOCKS_PER_BIT   = DEF_CPB
) (
  input logic                clk,
  input logic                reset,
  uart_transceiver_if.slave  bus
);
  uart_tx #(.W(INPUT_DATA_WIDTH), .CPB(CLOCKS_PER_BIT)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .data   (bus.i_data),
    .busy   (bus.o_busy),
    .line   (bus.serial_out)
  );

  uart_rx #(.W(INPUT_DATA_WIDTH), .CPB(CLOCKS_PER_BIT)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .serial (bus.serial_in),
    .data   (bus.received_data),
    .valid  (bus.data_is_valid),
    .error  (bus.rx_error)
  );
endmodule

// File: tb/tb_uart_transceiver.sv
// Random and directed frames against a bit-level frame model and a word queue.
module tb_uart_transceiver;
  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int FB  = (W + 2) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop = 1'b1;
  logic drv  = 1'b1;
  always #5 clk = ~clk;

  uart_transceiver_if #(.W(W)) bus ();
  assign bus.serial_in = loop ? bus.serial_out : drv;

  uart_transceiver #(.INPUT_DATA_WIDTH(W), .CLOCKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] rxq[$];
  int errs = 0;
  int both = 0;
  logic [W-1:0] last_rx;
  logic [W-1:0] w;

  always @(negedge clk) begin
    if (bus.data_is_valid) rxq.push_back(bus.received_data);
    if (bus.rx_error) errs++;
    if (bus.data_is_valid && bus.rx_error) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Bit k of a frame: 0 = start, 1..W = data LSB first, W+1 = stop.
  function automatic logic frame_bit(input logic [W-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return d[k-1];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string tag, input logic [W-1:0] d);
    chk({tag, "_cnt"}, rxq.size(), 1);
    if (rxq.size() == 1) chk({tag, "_data"}, rxq[0], d);
  endtask

  // Caller sets enable/i_data before the edge that accepts the frame.
  task automatic run_frame(input logic [W-1:0] d, input bit hold, input int poke_at);
    for (int c = 0; c < FB; c++) begin
      tick();
      if (c == 0 && !hold) bus.enable = 1'b0;
      if (c == 0 && hold)  bus.i_data = ~d;
      if (poke_at >= 0 && c == poke_at) begin
        bus.enable = 1'b1;
        bus.i_data = 8'h77;
      end
      if (poke_at >= 0 && c == poke_at + 1) bus.enable = 1'b0;
      chk("busy", bus.o_busy, 1);
      chk("txbit", bus.serial_out, frame_bit(d, c / CPB));
    end
    tick();
    chk("busy_end", bus.o_busy, 0);
    chk("idle_line", bus.serial_out, 1);
  endtask

  task automatic send_loop(input logic [W-1:0] d);
    rxq.delete();
    bus.i_data = d;
    bus.enable = 1'b1;
    run_frame(d, 1'b0, -1);
    tick();
    tick();
    chk_rx("loop_rx", d);
    last_rx = d;
  endtask

  task automatic drive_frame(input logic [W-1:0] d, input logic stop);
    for (int k = 0; k < W + 2; k++) begin
      drv = (k == W + 1) ? stop : frame_bit(d, k);
      repeat (CPB) tick();
    end
    drv = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.i_data = '0;
    last_rx    = '0;
    repeat (3) tick();
    chk("rst_line", bus.serial_out, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_rdata", bus.received_data, 0);
    chk("rst_valid", bus.data_is_valid, 0);
    chk("rst_err", bus.rx_error, 0);
    reset = 1'b0;
    tick();

    send_loop(8'hA5);

    // enable held: 0x00 then 0xFF with only the single idle cycle between
    rxq.delete();
    bus.i_data = 8'h00;
    bus.enable = 1'b1;
    run_frame(8'h00, 1'b1, -1);
    run_frame(8'hFF, 1'b0, -1);
    tick();
    tick();
    chk("b2b_cnt", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("b2b_0", rxq[0], 8'h00);
      chk("b2b_1", rxq[1], 8'hFF);
    end

    // enable and i_data poked mid-frame must be ignored
    rxq.delete();
    bus.i_data = 8'h3C;
    bus.enable = 1'b1;
    run_frame(8'h3C, 1'b0, 10);
    repeat (3) tick();
    chk("poke_busy", bus.o_busy, 0);
    chk_rx("poke_rx", 8'h3C);

    repeat (6) begin
      w = W'($urandom);
      send_loop(w);
    end

    // reset in the middle of a TX frame
    bus.i_data = W'($urandom);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    #1;
    chk("mid_line", bus.serial_out, 1);
    chk("mid_busy", bus.o_busy, 0);
    chk("mid_rdata", bus.received_data, 0);
    chk("mid_valid", bus.data_is_valid, 0);
    chk("mid_err", bus.rx_error, 0);
    repeat (2) tick();
    reset = 1'b0;
    rxq.delete();
    repeat (5) tick();
    chk("mid_nopart", rxq.size(), 0);
    send_loop(8'h5A);
    chk("loop_noerr", errs, 0);

    // externally driven RX
    loop = 1'b0;
    drv  = 1'b1;
    repeat (4) tick();
    rxq.delete();
    drive_frame(8'h81, 1'b0);
    chk("ferr_pulse", errs, 1);
    chk("ferr_novalid", rxq.size(), 0);
    chk("ferr_keep", bus.received_data, last_rx);

    drv = 1'b0;
    tick();
    drv = 1'b1;
    repeat (3 * CPB) tick();
    chk("glitch_nov", rxq.size(), 0);
    chk("glitch_noerr", errs, 1);

    rxq.delete();
    drive_frame(8'h42, 1'b1);
    chk_rx("rx42", 8'h42);

    repeat (6) begin
      w = W'($urandom);
      repeat ($urandom_range(0, CPB)) tick();
      rxq.delete();
      drive_frame(w, 1'b1);
      chk_rx("rx_rand", w);
    end
    chk("rx_errs", errs, 1);
    chk("never_both", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
